huffman_job_sched: RTL and testbench

- Schedules encoding jobs from two requesters onto a single shared huffman encoder instance.
- Grants requesters round-robin and clears the encoder's histogram between jobs.
- Streams each job's symbols from the granted requester's buffer into the encoder as one gap-free gray_valid burst.
- Signals job completion after the encoder's fixed code-build time, since the encoder's code_valid is not usable as a completion flag.

---
 rtl/huffman_job_sched.sv | 159 +++++++++++++++
 tb/tb_huffman_job_sched.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_job_sched.sv
// Round-robin scheduler sharing one huffman encoder between two requesters:
// clears the encoder, streams the job's symbols, then times the code build.
module huffman_job_sched #(
   parameter int CODE_WAIT = 80,
   parameter int CNT_TMO   = 4
) (
   input  logic       i_clk,
   input  logic       i_reset,           // asynchronous, active-low
   input  logic [1:0] i_req,
   input  logic [7:0] i_len0,
   input  logic [7:0] i_len1,
   output logic [1:0] o_gnt,
   output logic       o_src_rd,
   output logic [7:0] o_src_addr,
   input  logic [7:0] i_src_data,
   output logic       o_enc_reset,
   output logic       o_gray_valid,
   output logic [7:0] o_gray_data,
   input  logic       i_enc_cnt_valid,
   output logic [1:0] o_done,
   output logic       o_err,
   output logic       o_busy
);

   // state | meaning
   // IDLE  | no job; waiting for any request
   // ARB   | pick winner round-robin, latch its length
   // CLR   | one-cycle encoder histogram clear
   // FEED  | one buffer read per cycle, addresses 0..len-1
   // DRAIN | wait for the encoder count pulse, bounded by CNT_TMO
   // WAIT  | fixed code-build time before reporting completion
   // DONE  | completion pulse to the granted requester
   typedef enum logic [2:0] {
      S_IDLE, S_ARB, S_CLR, S_FEED, S_DRAIN, S_WAIT, S_DONE
   } state_t;

   // One counter serves both the drain timeout and the code-build wait.
   localparam int CW = $clog2(CODE_WAIT) + 1;
   localparam logic [CW-1:0] TMO_LD  = CW'(CNT_TMO - 1);
   localparam logic [CW-1:0] WAIT_LD = CW'(CODE_WAIT - 2);

   state_t        r_state;
   state_t        w_next;
   logic [1:0]    r_gnt;
   logic          r_gidx;
   logic          r_rr;
   logic          r_err;
   logic [7:0]    r_len;
   logic [7:0]    r_addr;
   logic [CW-1:0] r_cnt;
   logic          r_gray_valid;

   logic          w_win_idx;
   logic [1:0]    w_win_oh;
   logic [7:0]    w_win_len;
   logic          w_last;

   assign w_win_idx = (i_req == 2'b11) ? r_rr : i_req[1];
   assign w_win_oh  = {w_win_idx, ~w_win_idx};
   assign w_win_len = w_win_idx ? i_len1 : i_len0;
   assign w_last    = (r_addr == (r_len - 8'd1));

   assign o_src_addr   = r_addr;
   assign o_gray_valid = r_gray_valid;
   assign o_gray_data  = i_src_data;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      o_gnt       = r_gnt;
      o_src_rd    = 1'b0;
      o_enc_reset = 1'b0;
      o_done      = 2'b00;
      o_err       = 1'b0;
      o_busy      = (r_state != S_IDLE);
      case (r_state)
         S_IDLE: if (|i_req) w_next = S_ARB;
         S_ARB: begin
            if (|i_req) begin
               o_gnt  = w_win_oh;
               w_next = (w_win_len == 8'd0) ? S_DONE : S_CLR;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_CLR: begin
            o_enc_reset = 1'b1;
            w_next      = S_FEED;
         end
         S_FEED: begin
            o_src_rd = 1'b1;
            if (w_last) w_next = S_DRAIN;
         end
         S_DRAIN: begin
            if (i_enc_cnt_valid)    w_next = S_WAIT;
            else if (r_cnt == '0)   w_next = S_DONE;
         end
         S_WAIT: if (r_cnt == '0) w_next = S_DONE;
         S_DONE: begin
            o_done = r_gnt;
            o_err  = r_err;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_gnt        <= 2'b00;
         r_gidx       <= 1'b0;
         r_rr         <= 1'b0;
         r_err        <= 1'b0;
         r_len        <= 8'd0;
         r_addr       <= 8'd0;
         r_cnt        <= '0;
         r_gray_valid <= 1'b0;
      end else begin
         r_gray_valid <= o_src_rd;
         case (r_state)
            S_ARB: begin
               if (|i_req) begin
                  r_gnt  <= w_win_oh;
                  r_gidx <= w_win_idx;
                  r_len  <= w_win_len;
                  r_err  <= (w_win_len == 8'd0);
                  r_addr <= 8'd0;
               end
            end
            S_FEED: begin
               if (w_last) begin
                  r_addr <= 8'd0;
                  r_cnt  <= TMO_LD;
               end else begin
                  r_addr <= r_addr + 8'd1;
               end
            end
            S_DRAIN: begin
               if (i_enc_cnt_valid)  r_cnt <= WAIT_LD;
               else if (r_cnt == '0) r_err <= 1'b1;
               else                  r_cnt <= r_cnt - CW'(1);
            end
            S_WAIT: if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
            S_DONE: begin
               // Loser of this round is favoured next time both request.
               r_gnt <= 2'b00;
               r_rr  <= ~r_gidx;
               r_err <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_huffman_job_sched.sv
// Directed bench for huffman_job_sched: a buffer model, a negedge monitor
// that tallies handshake activity, and one task per scenario.
module tb_huffman_job_sched;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] req = 2'b00;
   logic [7:0] len0 = 8'd0;
   logic [7:0] len1 = 8'd0;
   logic [7:0] src_data = 8'd0;
   logic       enc_cnt_valid = 1'b0;
   logic [1:0] gnt;
   logic       src_rd;
   logic [7:0] src_addr;
   logic       enc_reset;
   logic       gray_valid;
   logic [7:0] gray_data;
   logic [1:0] done;
   logic       err;
   logic       busy;

   int vectors = 0;
   int miscompares = 0;

   huffman_job_sched dut (
      .i_clk(clk), .i_reset(rst_n), .i_req(req), .i_len0(len0), .i_len1(len1),
      .o_gnt(gnt), .o_src_rd(src_rd), .o_src_addr(src_addr), .i_src_data(src_data),
      .o_enc_reset(enc_reset), .o_gray_valid(gray_valid), .o_gray_data(gray_data),
      .i_enc_cnt_valid(enc_cnt_valid), .o_done(done), .o_err(err), .o_busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] mem_byte(input logic idx, input logic [7:0] a);
      return idx ? (a ^ 8'h5A) : (a * 8'd3 + 8'd1);
   endfunction

   // Requester buffers: data one cycle after the read strobe.
   always @(posedge clk) if (src_rd) src_data <= mem_byte(gnt[1], src_addr);

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Activity monitor; scenario tasks compare deltas of these tallies.
   int gv_total = 0, gv_runs = 0, gv_pos = 0, gv_first_cyc = 0, last_gv_cyc = 0;
   int data_bad = 0, rd_total = 0, er_total = 0, er_cyc = 0;
   int done_total = 0, done_cyc = 0, done_bad = 0, twohot = 0;
   logic [7:0] first_addr = 8'd0, last_addr = 8'd0;
   logic       prev_gv = 1'b0, prev_rd = 1'b0, done_err = 1'b0;
   logic [1:0] done_hist [16];

   always @(negedge clk) begin
      if (gray_valid) begin
         if (!prev_gv) gv_first_cyc = cyc;
         if (gray_data !== mem_byte(gnt[1], 8'(gv_pos))) data_bad++;
         gv_pos++;
         gv_total++;
         last_gv_cyc = cyc;
      end else begin
         if (prev_gv) gv_runs++;
         gv_pos = 0;
      end
      prev_gv = gray_valid;
      if (src_rd) begin
         if (!prev_rd) first_addr = src_addr;
         last_addr = src_addr;
         rd_total++;
      end
      prev_rd = src_rd;
      if (enc_reset) begin
         er_total++;
         er_cyc = cyc;
      end
      if (done != 2'b00) begin
         if (done !== gnt) done_bad++;
         done_hist[done_total % 16] = done;
         done_err = err;
         done_cyc = cyc;
         done_total++;
      end
      if (gnt == 2'b11) twohot++;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_done(input int budget);
      int s = done_total;
      int n = 0;
      while (done_total == s && n < budget) begin tick(); n++; end
      vectors++;
      if (done_total == s) begin
         miscompares++;
         $display("FAIL wait_done: no done pulse within %0d cycles", budget);
      end
   endtask

   task automatic wait_gv_end(input int budget);
      int s = gv_runs;
      int n = 0;
      while (gv_runs == s && n < budget) begin tick(); n++; end
      vectors++;
      if (gv_runs == s) begin
         miscompares++;
         $display("FAIL wait_gv_end: gray_valid burst did not end within %0d cycles", budget);
      end
   endtask

   task automatic pulse_cnt_valid(output int c);
      enc_cnt_valid = 1'b1;
      c = cyc;
      tick();
      enc_cnt_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req = 2'b00;
      tick(); tick();
      vectors++;
      if ({gnt, src_rd, src_addr, enc_reset, gray_valid, done, err, busy} !== 17'd0) begin
         miscompares++;
         $display("FAIL reset_in: outputs %h want 0", {gnt, src_rd, src_addr, enc_reset, gray_valid, done, err, busy});
      end
      rst_n = 1'b1;
      tick(); tick();
      vectors++;
      if ({gnt, busy, src_rd} !== 4'd0) begin
         miscompares++;
         $display("FAIL reset_idle: gnt/busy/rd %b want 0000", {gnt, busy, src_rd});
      end
   endtask

   task automatic test_single();
      int s_er = er_total, s_gv = gv_total, s_runs = gv_runs, s_bad = data_bad;
      int s_done = done_total;
      int c;
      len0 = 8'd10;
      req = 2'b01;
      tick();
      vectors++;
      if (gnt !== 2'b01 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL single_arb_gnt: gnt %b busy %b want 01 1", gnt, busy);
      end
      wait_gv_end(40);
      pulse_cnt_valid(c);
      wait_done(120);
      req = 2'b00;
      vectors++;
      if (done_hist[s_done % 16] !== 2'b01 || done_err !== 1'b0) begin
         miscompares++;
         $display("FAIL single_done: done %b err %b want 01 0", done_hist[s_done % 16], done_err);
      end
      vectors++;
      if (done_cyc - c != 80) begin
         miscompares++;
         $display("FAIL single_code_wait: %0d cycles want 80", done_cyc - c);
      end
      vectors++;
      if (er_total - s_er != 1) begin
         miscompares++;
         $display("FAIL single_enc_reset: %0d pulses want 1", er_total - s_er);
      end
      vectors++;
      if (gv_total - s_gv != 10 || gv_runs - s_runs != 1) begin
         miscompares++;
         $display("FAIL single_burst: %0d beats in %0d runs want 10 in 1", gv_total - s_gv, gv_runs - s_runs);
      end
      vectors++;
      if (data_bad != s_bad || first_addr !== 8'd0 || last_addr !== 8'd9) begin
         miscompares++;
         $display("FAIL single_data: bad %0d addr %0d..%0d want 0 0..9", data_bad - s_bad, first_addr, last_addr);
      end
      vectors++;
      if (gv_first_cyc - er_cyc != 2) begin
         miscompares++;
         $display("FAIL single_clr_to_gv: %0d cycles want 2", gv_first_cyc - er_cyc);
      end
   endtask

   task automatic test_zero_len();
      int s_er = er_total, s_gv = gv_total, s_rd = rd_total, s_done = done_total;
      len1 = 8'd0;
      req = 2'b10;
      wait_done(20);
      req = 2'b00;
      vectors++;
      if (done_hist[s_done % 16] !== 2'b10 || done_err !== 1'b1) begin
         miscompares++;
         $display("FAIL zero_done: done %b err %b want 10 1", done_hist[s_done % 16], done_err);
      end
      vectors++;
      if (er_total != s_er || gv_total != s_gv || rd_total != s_rd) begin
         miscompares++;
         $display("FAIL zero_quiet: enc_reset %0d gv %0d rd %0d want 0 0 0", er_total - s_er, gv_total - s_gv, rd_total - s_rd);
      end
   endtask

   task automatic test_timeout();
      int s_gv = gv_total, s_done = done_total;
      len0 = 8'd5;
      req = 2'b01;
      wait_gv_end(30);
      req = 2'b00;              // dropping req mid-job must not cancel it
      wait_done(20);
      vectors++;
      if (done_hist[s_done % 16] !== 2'b01 || done_err !== 1'b1) begin
         miscompares++;
         $display("FAIL tmo_done: done %b err %b want 01 1", done_hist[s_done % 16], done_err);
      end
      vectors++;
      if (done_cyc - last_gv_cyc != 4) begin
         miscompares++;
         $display("FAIL tmo_latency: %0d cycles after last gray_valid want 4", done_cyc - last_gv_cyc);
      end
      vectors++;
      if (gv_total - s_gv != 5) begin
         miscompares++;
         $display("FAIL tmo_beats: %0d want 5", gv_total - s_gv);
      end
   endtask

   task automatic test_contention();
      int s_done, s_bad = done_bad, s_two = twohot;
      logic [1:0] exp_g;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      s_done = done_total;
      len0 = 8'd3;
      len1 = 8'd2;
      req = 2'b11;
      for (int i = 0; i < 4; i++) begin
         wait_done(40);
         if (i == 3) req = 2'b00;
      end
      for (int i = 0; i < 4; i++) begin
         exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
         vectors++;
         if (done_hist[(s_done + i) % 16] !== exp_g) begin
            miscompares++;
            $display("FAIL rr_order job %0d: done %b want %b", i, done_hist[(s_done + i) % 16], exp_g);
         end
      end
      vectors++;
      if (done_bad != s_bad || twohot != s_two) begin
         miscompares++;
         $display("FAIL rr_gnt: done/gnt mismatches %0d two-hot cycles %0d want 0 0", done_bad - s_bad, twohot - s_two);
      end
   endtask

   task automatic test_max_len();
      int s_gv = gv_total, s_runs = gv_runs, s_bad = data_bad, s_done = done_total;
      int c;
      len0 = 8'd255;
      req = 2'b01;
      wait_gv_end(300);
      pulse_cnt_valid(c);
      wait_done(120);
      req = 2'b00;
      vectors++;
      if (gv_total - s_gv != 255 || gv_runs - s_runs != 1) begin
         miscompares++;
         $display("FAIL max_burst: %0d beats in %0d runs want 255 in 1", gv_total - s_gv, gv_runs - s_runs);
      end
      vectors++;
      if (first_addr !== 8'd0 || last_addr !== 8'd254 || data_bad != s_bad) begin
         miscompares++;
         $display("FAIL max_addr: %0d..%0d bad %0d want 0..254 0", first_addr, last_addr, data_bad - s_bad);
      end
      vectors++;
      if (done_hist[s_done % 16] !== 2'b01 || done_err !== 1'b0) begin
         miscompares++;
         $display("FAIL max_done: done %b err %b want 01 0", done_hist[s_done % 16], done_err);
      end
   endtask

   task automatic test_reset_mid_feed();
      int s_er = er_total, s_gv = gv_total, s_rd = rd_total, s_done = done_total, s_bad = data_bad;
      int n = 0;
      len0 = 8'd10;
      req = 2'b01;
      while (rd_total - s_rd < 3 && n < 30) begin tick(); n++; end
      vectors++;
      if (rd_total - s_rd != 3 || src_addr !== 8'd2) begin
         miscompares++;
         $display("FAIL midrst_reach: reads %0d addr %0d want 3 2", rd_total - s_rd, src_addr);
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({gnt, src_rd, src_addr, enc_reset, gray_valid, done, err, busy} !== 17'd0) begin
         miscompares++;
         $display("FAIL midrst_outputs: %h want 0", {gnt, src_rd, src_addr, enc_reset, gray_valid, done, err, busy});
      end
      tick(); tick();
      rst_n = 1'b1;
      wait_done(60);
      req = 2'b00;
      vectors++;
      if (done_total - s_done != 1 || done_hist[s_done % 16] !== 2'b01) begin
         miscompares++;
         $display("FAIL midrst_done: %0d pulses last %b want 1 01", done_total - s_done, done_hist[s_done % 16]);
      end
      vectors++;
      if (er_total - s_er != 2 || first_addr !== 8'd0) begin
         miscompares++;
         $display("FAIL midrst_restart: enc_reset %0d first addr %0d want 2 0", er_total - s_er, first_addr);
      end
      vectors++;
      if (gv_total - s_gv != 12 || data_bad != s_bad) begin
         miscompares++;
         $display("FAIL midrst_beats: %0d bad %0d want 12 0", gv_total - s_gv, data_bad - s_bad);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_zero_len();
      test_timeout();
      test_contention();
      test_max_len();
      test_reset_mid_feed();
      tick(); tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
